// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared types and helpers for the sprite address generator.
//                Holds the default coordinate/address widths, the coordinate
//                type, the per-channel sprite descriptor and a helper that
//                assembles a descriptor from fields sliced out of the packed
//                per-channel ports.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package sprite_pkg;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 18;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t w;
    coord_t h;
    addr_t  base;
    logic   dir;
  } sprite_desc_t;

  // Build one channel's descriptor from the fields taken out of the packed
  // per-channel port vectors.
  function automatic sprite_desc_t unpack_desc(
    input coord_t x,
    input coord_t y,
    input coord_t w,
    input coord_t h,
    input addr_t  base,
    input logic   dir
  );
    sprite_desc_t d;
    d.x    = x;
    d.y    = y;
    d.w    = w;
    d.h    = h;
    d.base = base;
    d.dir  = dir;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_anim_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_anim_ctr
//  Description : Per-channel animation counter. A divider counts frame_tick
//                pulses; every ANIM_DIV ticks the animation frame advances,
//                wrapping after NUM_FRAMES-1. While animation is disabled the
//                channel is held in its standing pose (divider and frame 0).
//  Ports       : frame_Clk  - clock
//                Reset      - synchronous, active-high
//                i_tick     - one-cycle pulse per video frame
//                i_anim_en  - animation running for this channel
//                o_frame    - current animation frame
//  Note        : NUM_FRAMES and ANIM_DIV must both be at least 2.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module sprite_anim_ctr #(
  parameter int NUM_FRAMES = 4,
  parameter int ANIM_DIV   = 6
) (
  input  logic                          frame_Clk,
  input  logic                          Reset,
  input  logic                          i_tick,
  input  logic                          i_anim_en,
  output logic [$clog2(NUM_FRAMES)-1:0] o_frame
);

  localparam int FRAME_W = $clog2(NUM_FRAMES);
  localparam int DIV_W   = $clog2(ANIM_DIV);

  logic [DIV_W-1:0]   r_div;
  logic [FRAME_W-1:0] r_frame;

  // Reset wins over everything, then the standing-pose clear, then the tick.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      r_div   <= '0;
      r_frame <= '0;
    end else if (!i_anim_en) begin
      r_div   <= '0;
      r_frame <= '0;
    end else if (i_tick) begin
      if (r_div == DIV_W'(ANIM_DIV - 1)) begin
        r_div <= '0;
        if (r_frame == FRAME_W'(NUM_FRAMES - 1)) begin
          r_frame <= '0;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_frame = r_frame;

endmodule
`default_nettype wire

// File: rtl/sprite_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_addr_gen
//  Description : Multi-channel sprite address generator. For every pixel
//                (DrawX, DrawY) the NUM_SPRITES rectangles are hit-tested,
//                the lowest-index hit wins, and its sprite-ROM address
//                base + bank + frame*(w*h) + row*w + col is produced two
//                cycles later. Owns one animation counter per channel.
//  Ports       : frame_Clk, Reset     - clock, synchronous active-high reset
//                DrawX, DrawY         - current pixel
//                frame_tick           - one pulse per video frame
//                spr_x/y/w/h          - packed per-channel rectangles
//                spr_base             - packed per-channel sheet base address
//                spr_dir              - 1 = facing left
//                spr_enable, anim_en  - per-channel visibility / animation
//                sprite_on, sprite_id - registered hit flag and winner
//                sprite_addr          - registered ROM address
//                frame_idx            - packed current frame per channel
//  Config      : SPRITE_MIRROR_EN - when defined, left-facing sprites are
//                drawn by flipping the column of the right-facing sheet;
//                otherwise they read a separate sheet at LEFT_BANK.
//  Note        : COORD_W/ADDR_W must match the sprite_pkg widths.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module sprite_addr_gen #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = sprite_pkg::COORD_W,
  parameter int ADDR_W      = sprite_pkg::ADDR_W,
  parameter int NUM_FRAMES  = 4,
  parameter int ANIM_DIV    = 6,
  parameter int LEFT_BANK   = 20736
) (
  input  logic                                     frame_Clk,
  input  logic                                     Reset,
  input  logic [COORD_W-1:0]                       DrawX,
  input  logic [COORD_W-1:0]                       DrawY,
  input  logic                                     frame_tick,
  input  logic [NUM_SPRITES*COORD_W-1:0]           spr_x,
  input  logic [NUM_SPRITES*COORD_W-1:0]           spr_y,
  input  logic [NUM_SPRITES*COORD_W-1:0]           spr_w,
  input  logic [NUM_SPRITES*COORD_W-1:0]           spr_h,
  input  logic [NUM_SPRITES*ADDR_W-1:0]            spr_base,
  input  logic [NUM_SPRITES-1:0]                   spr_dir,
  input  logic [NUM_SPRITES-1:0]                   spr_enable,
  input  logic [NUM_SPRITES-1:0]                   anim_en,
  output logic                                     sprite_on,
  output logic [$clog2(NUM_SPRITES)-1:0]           sprite_id,
  output logic [ADDR_W-1:0]                        sprite_addr,
  output logic [NUM_SPRITES*$clog2(NUM_FRAMES)-1:0] frame_idx
);

  import sprite_pkg::sprite_desc_t;
  import sprite_pkg::unpack_desc;

  localparam int ID_W    = $clog2(NUM_SPRITES);
  localparam int FRAME_W = $clog2(NUM_FRAMES);

  // --------------------------------------------------------------------------
  // Per-channel descriptors, hit test and animation counters
  // --------------------------------------------------------------------------
  sprite_desc_t           w_desc  [NUM_SPRITES];
  logic [FRAME_W-1:0]     w_frame [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_hit;

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_chan
    logic [COORD_W:0] w_x_end;
    logic [COORD_W:0] w_y_end;

    assign w_desc[gi] = unpack_desc(spr_x[gi*COORD_W +: COORD_W],
                                    spr_y[gi*COORD_W +: COORD_W],
                                    spr_w[gi*COORD_W +: COORD_W],
                                    spr_h[gi*COORD_W +: COORD_W],
                                    spr_base[gi*ADDR_W +: ADDR_W],
                                    spr_dir[gi]);

    // One extra bit so a rectangle touching the right/bottom edge of the
    // coordinate space does not wrap; w=0 or h=0 leaves an empty range.
    assign w_x_end = {1'b0, w_desc[gi].x} + {1'b0, w_desc[gi].w};
    assign w_y_end = {1'b0, w_desc[gi].y} + {1'b0, w_desc[gi].h};

    assign w_hit[gi] = spr_enable[gi]
                     && (DrawX >= w_desc[gi].x) && ({1'b0, DrawX} < w_x_end)
                     && (DrawY >= w_desc[gi].y) && ({1'b0, DrawY} < w_y_end);

    sprite_anim_ctr #(
      .NUM_FRAMES (NUM_FRAMES),
      .ANIM_DIV   (ANIM_DIV)
    ) u_anim (
      .frame_Clk  (frame_Clk),
      .Reset      (Reset),
      .i_tick     (frame_tick),
      .i_anim_en  (anim_en[gi]),
      .o_frame    (w_frame[gi])
    );

    assign frame_idx[gi*FRAME_W +: FRAME_W] = w_frame[gi];
  end

  // --------------------------------------------------------------------------
  // Priority encoder: scanning downwards leaves the lowest hit index.
  // --------------------------------------------------------------------------
  logic            w_any;
  logic [ID_W-1:0] w_win;

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any = 1'b1;
        w_win = ID_W'(i);
      end
    end
  end

  sprite_desc_t       w_sel;
  logic [COORD_W-1:0] w_col_raw;
  logic [COORD_W-1:0] w_col;
  logic [COORD_W-1:0] w_row;

  assign w_sel     = w_desc[w_win];
  assign w_col_raw = DrawX - w_sel.x;
  assign w_row     = DrawY - w_sel.y;

`ifdef SPRITE_MIRROR_EN
  // col < w whenever there is a hit, so w-1-col stays inside the sprite.
  assign w_col = w_sel.dir ? (w_sel.w - COORD_W'(1) - w_col_raw) : w_col_raw;
`else
  assign w_col = w_col_raw;
`endif

  // --------------------------------------------------------------------------
  // Stage 1: capture the winner
  // --------------------------------------------------------------------------
  logic               r_s1_hit;
  logic [ID_W-1:0]    r_s1_id;
  logic [COORD_W-1:0] r_s1_col;
  logic [COORD_W-1:0] r_s1_row;
  logic [COORD_W-1:0] r_s1_w;
  logic [COORD_W-1:0] r_s1_h;
  logic [ADDR_W-1:0]  r_s1_base;
  logic [FRAME_W-1:0] r_s1_frame;
`ifndef SPRITE_MIRROR_EN
  logic               r_s1_dir;
`endif

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      r_s1_hit   <= 1'b0;
      r_s1_id    <= '0;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
      r_s1_w     <= '0;
      r_s1_h     <= '0;
      r_s1_base  <= '0;
      r_s1_frame <= '0;
`ifndef SPRITE_MIRROR_EN
      r_s1_dir   <= 1'b0;
`endif
    end else begin
      r_s1_hit   <= w_any;
      r_s1_id    <= w_win;
      r_s1_col   <= w_col;
      r_s1_row   <= w_row;
      r_s1_w     <= w_sel.w;
      r_s1_h     <= w_sel.h;
      r_s1_base  <= w_sel.base;
      r_s1_frame <= w_frame[w_win];
`ifndef SPRITE_MIRROR_EN
      r_s1_dir   <= w_sel.dir;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: address arithmetic. The result is wanted modulo 2^ADDR_W, and
  // +/* commute with that truncation, so every term is evaluated directly at
  // ADDR_W bits and gives the same value as the full-width sum.
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_bank;
  logic [ADDR_W-1:0] w_addr;

`ifdef SPRITE_MIRROR_EN
  assign w_bank = '0;
`else
  assign w_bank = r_s1_dir ? ADDR_W'(LEFT_BANK) : '0;
`endif

  assign w_addr = r_s1_base + w_bank
                + ADDR_W'(r_s1_frame) * (ADDR_W'(r_s1_w) * ADDR_W'(r_s1_h))
                + ADDR_W'(r_s1_row) * ADDR_W'(r_s1_w)
                + ADDR_W'(r_s1_col);

  always_ff @(posedge frame_Clk) begin
    if (Reset || !r_s1_hit) begin
      sprite_on   <= 1'b0;
      sprite_id   <= '0;
      sprite_addr <= '0;
    end else begin
      sprite_on   <= 1'b1;
      sprite_id   <= r_s1_id;
      sprite_addr <= w_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_addr_gen
//  Description : Scoreboard bench for sprite_addr_gen. A driver applies one
//                pixel per cycle (directed cases, then random traffic) and
//                pushes the expected pixel result and frame_idx value into
//                queues; a monitor pops and compares them when they fall due.
//                The reference model counts enabled ticks per channel and
//                derives frames and addresses with plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_addr_gen;

  localparam int NS   = 4;
  localparam int CW   = 10;
  localparam int AW   = 18;
  localparam int NF   = 4;
  localparam int DIV  = 6;
  localparam int LBNK = 20736;

  logic              frame_Clk = 1'b0;
  logic              Reset;
  logic [CW-1:0]     DrawX, DrawY;
  logic              frame_tick;
  logic [NS*CW-1:0]  spr_x, spr_y, spr_w, spr_h;
  logic [NS*AW-1:0]  spr_base;
  logic [NS-1:0]     spr_dir, spr_enable, anim_en;
  logic              sprite_on;
  logic [1:0]        sprite_id;
  logic [AW-1:0]     sprite_addr;
  logic [NS*2-1:0]   frame_idx;

  sprite_addr_gen #(
    .NUM_SPRITES (NS), .COORD_W (CW), .ADDR_W (AW),
    .NUM_FRAMES (NF), .ANIM_DIV (DIV), .LEFT_BANK (LBNK)
  ) dut (
    .frame_Clk (frame_Clk), .Reset (Reset), .DrawX (DrawX), .DrawY (DrawY),
    .frame_tick (frame_tick), .spr_x (spr_x), .spr_y (spr_y), .spr_w (spr_w),
    .spr_h (spr_h), .spr_base (spr_base), .spr_dir (spr_dir),
    .spr_enable (spr_enable), .anim_en (anim_en), .sprite_on (sprite_on),
    .sprite_id (sprite_id), .sprite_addr (sprite_addr), .frame_idx (frame_idx)
  );

  always #5 frame_Clk = ~frame_Clk;

  int cyc = 0;
  always @(posedge frame_Clk) cyc <= cyc + 1;

  // Stimulus state
  int sx[NS], sy[NS], sw[NS], sh[NS], sbase[NS];
  bit sdir[NS], sen[NS], aen[NS];
  int dx, dy;
  bit tick, rst;

  // Reference model: ticks seen while animation enabled, per channel
  int cnt[NS];

  typedef struct {
    int         due;
    logic       on;
    logic [1:0] id;
    logic [AW-1:0] addr;
  } pix_t;

  typedef struct {
    int            due;
    logic [NS*2-1:0] fr;
  } frm_t;

  pix_t pq[$];
  frm_t fq[$];

  int checks = 0;
  int errors = 0;

  function automatic int model_frame(int i);
    return (cnt[i] / DIV) % NF;
  endfunction

  function automatic pix_t model_pixel(int due);
    pix_t r;
    r.due = due; r.on = 1'b0; r.id = 2'd0; r.addr = '0;
    for (int i = 0; i < NS; i++) begin
      if (sen[i] && dx >= sx[i] && dx < sx[i] + sw[i] &&
          dy >= sy[i] && dy < sy[i] + sh[i]) begin
        longint col, row, bank, a;
        col  = dx - sx[i];
        row  = dy - sy[i];
        bank = 0;
`ifdef SPRITE_MIRROR_EN
        if (sdir[i]) col = sw[i] - 1 - col;
`else
        if (sdir[i]) bank = LBNK;
`endif
        a = sbase[i] + bank + longint'(model_frame(i)) * sw[i] * sh[i]
            + row * sw[i] + col;
        r.on   = 1'b1;
        r.id   = 2'(i);
        r.addr = a[AW-1:0];
        return r;
      end
    end
    return r;
  endfunction

  task automatic set_spr(int i, int x, int y, int w, int h, int base, bit dir, bit en);
    sx[i] = x; sy[i] = y; sw[i] = w; sh[i] = h; sbase[i] = base;
    sdir[i] = dir; sen[i] = en;
  endtask

  // One cycle: drive at the falling edge, then record what the DUT owes us.
  task automatic step();
    pix_t  p;
    frm_t  f;
    @(negedge frame_Clk);
    for (int i = 0; i < NS; i++) begin
      spr_x[i*CW +: CW]    = CW'(sx[i]);
      spr_y[i*CW +: CW]    = CW'(sy[i]);
      spr_w[i*CW +: CW]    = CW'(sw[i]);
      spr_h[i*CW +: CW]    = CW'(sh[i]);
      spr_base[i*AW +: AW] = AW'(sbase[i]);
      spr_dir[i]    = sdir[i];
      spr_enable[i] = sen[i];
      anim_en[i]    = aen[i];
    end
    DrawX = CW'(dx); DrawY = CW'(dy);
    frame_tick = tick; Reset = rst;
    if (rst) begin
      // The pixel already in stage 1 is flushed by this reset too.
      foreach (pq[k]) if (pq[k].due == cyc + 1) begin
        pq[k].on = 1'b0; pq[k].id = 2'd0; pq[k].addr = '0;
      end
      p.due = cyc + 2; p.on = 1'b0; p.id = 2'd0; p.addr = '0;
      for (int i = 0; i < NS; i++) cnt[i] = 0;
    end else begin
      p = model_pixel(cyc + 2);
      for (int i = 0; i < NS; i++) begin
        if (!aen[i]) cnt[i] = 0;
        else if (tick) cnt[i]++;
      end
    end
    pq.push_back(p);
    f.due = cyc + 1;
    f.fr  = '0;
    for (int i = 0; i < NS; i++) f.fr[i*2 +: 2] = 2'(model_frame(i));
    fq.push_back(f);
  endtask

  // Monitor
  always @(negedge frame_Clk) begin
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      pix_t e;
      e = pq.pop_front();
      checks++;
      if (e.due != cyc || sprite_on !== e.on || sprite_id !== e.id || sprite_addr !== e.addr) begin
        errors++;
        $display("FAIL pixel cyc=%0d due=%0d: got on=%0b id=%0d addr=%0d, expected on=%0b id=%0d addr=%0d",
                 cyc, e.due, sprite_on, sprite_id, sprite_addr, e.on, e.id, e.addr);
      end
    end
    while (fq.size() > 0 && fq[0].due <= cyc) begin
      frm_t e;
      e = fq.pop_front();
      checks++;
      if (e.due != cyc || frame_idx !== e.fr) begin
        errors++;
        $display("FAIL frame_idx cyc=%0d: got %h, expected %h", cyc, frame_idx, e.fr);
      end
    end
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      set_spr(i, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      aen[i] = 1'b0; cnt[i] = 0;
    end
    tick = 1'b0;

    // Reset held 3 cycles with the pixel inside sprite 0
    set_spr(0, 100, 50, 24, 45, 0, 1'b0, 1'b1);
    aen[0] = 1'b1; tick = 1'b1;
    dx = 105; dy = 52; rst = 1'b1;
    repeat (3) step();
    rst = 1'b0; tick = 1'b0; aen[0] = 1'b0;
    repeat (3) step();

    // Single hit and rectangle edges (expected addr 53 for the first one)
    dx = 105; dy = 52; step();
    dx = 124; dy = 52; step();
    dx = 100; dy = 50; step();
    dx = 123; dy = 94; step();
    dx = 105; dy = 95; step();
    dx = 99;  dy = 60; step();

    // Priority between overlapping sprites 0 and 2
    set_spr(2, 90, 40, 30, 30, 4000, 1'b0, 1'b1);
    dx = 105; dy = 52; step();
    sen[0] = 1'b0; step();
    sen[0] = 1'b1;
    set_spr(2, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Animation on channel 1: 24 ticks walk through every frame and wrap
    aen[1] = 1'b1;
    for (int t = 0; t < 24; t++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
    tick = 1'b1; repeat (8) step();
    aen[1] = 1'b0; tick = 1'b0; repeat (2) step();

    // Direction: col 5, row 0
    sbase[0] = 1000; sdir[0] = 1'b1;
    dx = 105; dy = 50; step();
    sdir[0] = 1'b0;
    // Frame 2 on sprite 0
    aen[0] = 1'b1; tick = 1'b1;
    repeat (12) step();
    tick = 1'b0;
    dx = 105; dy = 50; repeat (2) step();
    sdir[0] = 1'b1; step();
    sdir[0] = 1'b0; aen[0] = 1'b0;

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < NS; i++) begin
          int x, y;
          x = ($urandom_range(0, 9) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 300);
          y = ($urandom_range(0, 9) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 300);
          set_spr(i, x, y, $urandom_range(0, 60), $urandom_range(0, 60),
                  $urandom_range(0, (1 << AW) - 1), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0));
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        for (int i = 0; i < NS; i++) aen[i] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) != 0) begin
        int j;
        j  = $urandom_range(0, NS - 1);
        dx = sx[j] + $urandom_range(0, sw[j] + 1) - 1;
        dy = sy[j] + $urandom_range(0, sh[j] + 1) - 1;
      end else begin
        dx = $urandom_range(0, 1023);
        dy = $urandom_range(0, 1023);
      end
      if (dx < 0) dx = 0;
      if (dx > 1023) dx = 1023;
      if (dy < 0) dy = 0;
      if (dy > 1023) dy = 1023;
      tick = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; tick = 1'b0;
    repeat (2) step();

    repeat (4) @(posedge frame_Clk);
    @(negedge frame_Clk);
    #1;
    if (pq.size() != 0 || fq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard drain: %0d pixel and %0d frame entries left, expected 0",
               pq.size(), fq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
